// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_OVL  = 1'b0;
  localparam logic MODE_NOVL = 1'b1;

endpackage

// File: rtl/seq_detector_if.sv
// Control/data bundle between a serial source and seq_detector.
interface seq_detector_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             A;
  logic             mode;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output en, A, mode, pat_load, pat_in, cnt_clr,
    input  y, match_cnt, armed
  );

  modport slave (
    input  en, A, mode, pat_load, pat_in, cnt_clr,
    output y, match_cnt, armed
  );
endinterface

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Moore serial pattern detector: registered match pulse, overlap/non-overlap modes,
// runtime-loadable pattern and saturating match counter.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned   N       = 2,
  parameter int unsigned   CNT_W   = 8,
  parameter logic [N-1:0]  PAT_RST = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic           clk,
  input  logic           reset,
  seq_detector_if.slave  bus
);

  localparam int unsigned FW = $clog2(N + 1);

  state_t         state, state_nxt;
  logic [N-1:0]   pat, pat_nxt;
  // The oldest history bit is shifted out before every compare, so only N-1 are kept.
  logic [N-2:0]   hist, hist_nxt;
  logic [N-1:0]   shifted;
  logic [FW-1:0]  fill, fill_nxt;
  logic           y_q, y_nxt;
  logic           hit;

  always_comb begin
    shifted   = {hist, bus.A};
    state_nxt = state;
    pat_nxt   = pat;
    hist_nxt  = hist;
    fill_nxt  = fill;
    y_nxt     = 1'b0;
    hit       = 1'b0;

    if (bus.pat_load) begin
      pat_nxt   = bus.pat_in;
      fill_nxt  = '0;
      state_nxt = ST_FILL;
    end else if (bus.en) begin
      hist_nxt = shifted[N-2:0];
      hit      = ((state == ST_RUN) || (fill == FW'(N - 1))) && (shifted == pat);
      y_nxt    = hit;
      if (hit && (bus.mode == MODE_NOVL)) begin
        fill_nxt  = '0;
        state_nxt = ST_FILL;
      end else if (state == ST_FILL) begin
        fill_nxt = fill + 1'b1;
        if (fill == FW'(N - 1)) begin
          state_nxt = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FILL;
      pat   <= PAT_RST;
      hist  <= '0;
      fill  <= '0;
      y_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      pat   <= pat_nxt;
      hist  <= hist_nxt;
      fill  <= fill_nxt;
      y_q   <= y_nxt;
    end
  end

  assign bus.y     = y_q;
  assign bus.armed = (state == ST_RUN);

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .q     (bus.match_cnt)
  );

endmodule

// File: tb/tb_seq_detector.sv
// Directed self-checking bench for seq_detector (N=2/CNT_W=2 and N=3/CNT_W=8 instances).
module tb_seq_detector;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_detector_if #(.N(2), .CNT_W(2)) if2 ();
  seq_detector_if #(.N(3), .CNT_W(8)) if3 ();

  seq_detector #(.N(2), .CNT_W(2), .PAT_RST(2'b01)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  seq_detector #(.N(3), .CNT_W(8)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (if2.y !== 1'b0 || if2.armed !== 1'b0 || if2.match_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_n2: y=%b armed=%b cnt=%0d expected 0/0/0", if2.y, if2.armed, if2.match_cnt);
    end
    checks++;
    if (if3.y !== 1'b0 || if3.armed !== 1'b0 || if3.match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_n3: y=%b armed=%b cnt=%0d expected 0/0/0", if3.y, if3.armed, if3.match_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_defaults();
    logic [4:0] a_seq = 5'b01001;
    logic [4:0] y_exp = 5'b01001;
    if2.mode = MODE_OVL;
    for (int i = 4; i >= 0; i--) begin
      if2.en = 1'b1;
      if2.A  = a_seq[i];
      cyc();
      checks++;
      if (if2.y !== y_exp[i]) begin
        errors++;
        $display("FAIL defaults_y bit%0d: got %b expected %b", 5 - i, if2.y, y_exp[i]);
      end
    end
    if2.en = 1'b0;
    checks++;
    if (if2.match_cnt !== 2'd2 || if2.armed !== 1'b1) begin
      errors++;
      $display("FAIL defaults_cnt: cnt=%0d armed=%b expected 2/1", if2.match_cnt, if2.armed);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] a_seq = 5'b10101;
    logic [4:0] y_ovl = 5'b00101;
    logic [4:0] y_nov = 5'b00100;
    for (int m = 0; m < 2; m++) begin
      if3.en       = 1'b0;
      if3.pat_load = 1'b1;
      if3.pat_in   = 3'b101;
      cyc();
      if3.pat_load = 1'b0;
      checks++;
      if (if3.armed !== 1'b0) begin
        errors++;
        $display("FAIL overlap_load_armed m%0d: got %b expected 0", m, if3.armed);
      end
      if3.mode = (m == 0) ? MODE_OVL : MODE_NOVL;
      for (int i = 4; i >= 0; i--) begin
        if3.en = 1'b1;
        if3.A  = a_seq[i];
        cyc();
        checks++;
        if (if3.y !== ((m == 0) ? y_ovl[i] : y_nov[i])) begin
          errors++;
          $display("FAIL overlap_y m%0d bit%0d: got %b expected %b", m, 5 - i, if3.y,
                   (m == 0) ? y_ovl[i] : y_nov[i]);
        end
      end
      if3.en = 1'b0;
    end
    checks++;
    if (if3.match_cnt !== 8'd3 || if3.armed !== 1'b0) begin
      errors++;
      $display("FAIL overlap_cnt: cnt=%0d armed=%b expected 3/0", if3.match_cnt, if3.armed);
    end
  endtask

  task automatic test_enable_gap();
    if2.en       = 1'b0;
    if2.pat_load = 1'b1;
    if2.pat_in   = 2'b01;
    cyc();
    if2.pat_load = 1'b0;
    if2.en = 1'b1;
    if2.A  = 1'b0;
    cyc();
    if2.en = 1'b0;
    if2.A  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (if2.y !== 1'b0 || if2.armed !== 1'b0 || if2.match_cnt !== 2'd2) begin
        errors++;
        $display("FAIL gap_idle c%0d: y=%b armed=%b cnt=%0d expected 0/0/2", i, if2.y, if2.armed, if2.match_cnt);
      end
    end
    if2.en = 1'b1;
    cyc();
    checks++;
    if (if2.y !== 1'b1 || if2.armed !== 1'b1) begin
      errors++;
      $display("FAIL gap_match: y=%b armed=%b expected 1/1", if2.y, if2.armed);
    end
    if2.en = 1'b0;
    cyc();
    checks++;
    if (if2.y !== 1'b0 || if2.match_cnt !== 2'd3) begin
      errors++;
      $display("FAIL gap_pulse_end: y=%b cnt=%0d expected 0/3", if2.y, if2.match_cnt);
    end
  endtask

  task automatic test_load();
    if2.en = 1'b1;
    if2.A  = 1'b0;
    cyc();
    if2.pat_load = 1'b1;
    if2.pat_in   = 2'b10;
    if2.A        = 1'b1;
    cyc();
    if2.pat_load = 1'b0;
    checks++;
    if (if2.y !== 1'b0 || if2.armed !== 1'b0 || if2.match_cnt !== 2'd3) begin
      errors++;
      $display("FAIL load_wins: y=%b armed=%b cnt=%0d expected 0/0/3", if2.y, if2.armed, if2.match_cnt);
    end
    if2.A = 1'b1;
    cyc();
    checks++;
    if (if2.y !== 1'b0) begin
      errors++;
      $display("FAIL load_first_bit: y=%b expected 0", if2.y);
    end
    if2.A = 1'b0;
    cyc();
    checks++;
    if (if2.y !== 1'b1 || if2.armed !== 1'b1 || if2.match_cnt !== 2'd3) begin
      errors++;
      $display("FAIL load_match: y=%b armed=%b cnt=%0d expected 1/1/3", if2.y, if2.armed, if2.match_cnt);
    end
    if2.en = 1'b0;
  endtask

  task automatic test_saturation();
    if2.cnt_clr = 1'b1;
    cyc();
    if2.cnt_clr = 1'b0;
    checks++;
    if (if2.match_cnt !== 2'd0) begin
      errors++;
      $display("FAIL sat_clear: cnt=%0d expected 0", if2.match_cnt);
    end
    if2.en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if2.A = 1'b1;
      cyc();
      if2.A = 1'b0;
      cyc();
      checks++;
      if (if2.y !== 1'b1 || if2.match_cnt !== ((k < 3) ? 2'(k) : 2'd3)) begin
        errors++;
        $display("FAIL sat_count k%0d: y=%b cnt=%0d expected 1/%0d", k, if2.y, if2.match_cnt, (k < 3) ? k : 3);
      end
    end
    if2.A = 1'b1;
    cyc();
    if2.A       = 1'b0;
    if2.cnt_clr = 1'b1;
    cyc();
    if2.cnt_clr = 1'b0;
    checks++;
    if (if2.y !== 1'b1 || if2.match_cnt !== 2'd0) begin
      errors++;
      $display("FAIL sat_clr_vs_match: y=%b cnt=%0d expected 1/0", if2.y, if2.match_cnt);
    end
    if2.en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [2:0] a_seq = 3'b101;
    logic [2:0] y_exp = 3'b001;
    if2.en = 1'b1;
    if2.A  = 1'b1;
    cyc();
    if2.A = 1'b0;
    cyc();
    checks++;
    if (if2.y !== 1'b1 || if2.match_cnt !== 2'd1) begin
      errors++;
      $display("FAIL arst_pre: y=%b cnt=%0d expected 1/1", if2.y, if2.match_cnt);
    end
    if2.en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (if2.y !== 1'b0 || if2.armed !== 1'b0 || if2.match_cnt !== 2'd0 || if3.match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL arst_immediate: y=%b armed=%b cnt2=%0d cnt3=%0d expected 0/0/0/0",
               if2.y, if2.armed, if2.match_cnt, if3.match_cnt);
    end
    #2;
    reset = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if2.en = 1'b1;
      if2.A  = a_seq[i];
      cyc();
      checks++;
      if (if2.y !== y_exp[i]) begin
        errors++;
        $display("FAIL arst_patrst bit%0d: got %b expected %b", 3 - i, if2.y, y_exp[i]);
      end
    end
    if2.en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if2.en = 1'b0; if2.A = 1'b0; if2.mode = 1'b0; if2.pat_load = 1'b0; if2.pat_in = '0; if2.cnt_clr = 1'b0;
    if3.en = 1'b0; if3.A = 1'b0; if3.mode = 1'b0; if3.pat_load = 1'b0; if3.pat_in = '0; if3.cnt_clr = 1'b0;
    test_reset();
    test_defaults();
    test_overlap();
    test_enable_gap();
    test_load();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised Moore serial-pattern detector, the generalised successor of the fixed two-bit detector in the digital-design exercises. It samples one serial input bit per enabled clock and raises a one-cycle registered pulse when the last `N` sampled bits equal a runtime-loadable pattern. Both overlapping and non-overlapping match modes are supported, and a saturating match counter is included. It sits directly on a synchronous serial line, with its outputs feeding LEDs or a downstream controller.

## Interface
Parameters:
- `N`, 2: pattern length in bits; legal range 2..16.
- `CNT_W`, 8: width of the match counter.
- `PAT_RST`, `'b01` (zero-extended to `N`): pattern value loaded by reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `en`, in, 1: sample enable; `A` is consumed only on edges where `en`=1.
- `A`, in, 1: serial data bit.
- `mode`, in, 1: 0 = overlapping, 1 = non-overlapping; sampled every enabled edge.
- `pat_load`, in, 1: load `pat_in` into the pattern register and restart detection.
- `pat_in`, in, `N`: new pattern; `pat_in[N-1]` is the first bit expected, `pat_in[0]` the last.
- `cnt_clr`, in, 1: synchronous clear of `match_cnt`.
- `y`, out, 1: match pulse, registered.
- `match_cnt`, out, `CNT_W`: saturating count of matches.
- `armed`, out, 1: high when `N` valid bits are held in history.

## Operation
- Registers:
  - `pat` (`N` bits).
  - `hist` (`N`-bit shift register). On an enabled edge, `hist <= {hist[N-2:0], A}`.
  - `fill` (0..`N`, `$clog2(N+1)` bits): count of valid history bits.
- FSM, two states (`FILL`, `RUN`):
  - `FILL`: `fill` < `N`. Each enabled edge increments `fill`; reaching `N` moves the FSM to `RUN`.
  - `RUN`: every enabled edge shifts `hist`. The match test uses the post-shift value `{hist[N-2:0], A} == pat`.
- Match handling on an enabled edge:
  - The post-shift history is compared only once `N` valid bits will be present, i.e. in `RUN`, or in `FILL` when `fill` = `N-1`.
  - A match sets `y` for the next cycle.
  - `mode`=0: history is kept, so a matched suffix can start the next match.
  - `mode`=1: after a match, `fill` is cleared to 0 and the FSM returns to `FILL`. The bits of the matched sequence are never reused.
- `y` is a registered one-cycle pulse: it is high in the cycle after the completing edge and low otherwise. When `en`=0, `y` is forced low on that edge and no state advances.
- `match_cnt` increments on each match and saturates at 2^`CNT_W`−1.
- `cnt_clr` takes priority over an increment on the same edge (result is 0).
- `pat_load`:
  - Loads `pat`, clears `fill`, enters `FILL`, and drives `y` to 0.
  - Any `A` sampled on that same edge is discarded.
  - Takes priority over `en`.
  - Does not affect `match_cnt`.
- Reset values:
  - `pat` = `PAT_RST`, `hist` = 0, `fill` = 0, state = `FILL`.
  - `y` = 0, `match_cnt` = 0, `armed` = 0.
- `armed` is high exactly when the state is `RUN`.

## Timing
- Latency: 1 cycle from the completing sampling edge to `y` high.
- Sustained throughput: one bit per clock with `en` held high.
  - Overlapping mode with `pat` = `11`: the input `1,1,1,1` gives `y` pulses after the 2nd, 3rd and 4th bits.
  - Non-overlapping mode, same input: pulses after the 2nd and 4th bits only.
- Reset asserted mid-sequence: outputs drop asynchronously. After release, the first match requires `N` fresh enabled bits.
- When `pat_load` and a would-be match occur on the same edge, the load wins: no pulse and no count.
- Simultaneous match and `cnt_clr`: `y` pulses and `match_cnt` becomes 0.

## Structure
- Package `seq_det_pkg`:
  - State encoding constants `ST_FILL` = 1'b0 and `ST_RUN` = 1'b1.
  - Mode constants `MODE_OVL` = 1'b0 and `MODE_NOVL` = 1'b1.
- Sub-module `sat_counter` (parameter `W`; ports clock, reset, `inc`, `clr`, `q`) implements `match_cnt`.
- Everything else (history, fill, FSM, compare) lives in `seq_detector`.

## Test plan
- Reset defaults (`N`=2, `pat`=`01`): serial input `0,1,0,0,1` with `en`=1 → `y` pulses after bits 2 and 5; `match_cnt`=2.
- Overlap vs non-overlap (`N`=3, load `101`):
  - `mode`=0 with input `1,0,1,0,1` → 2 pulses (after bits 3 and 5).
  - `mode`=1, same input → 1 pulse (after bit 3).
- Enable gaps: input `0,1` with `en` dropped for 3 cycles between the two bits → `y` pulses one cycle after the `1` is sampled; no pulse and no state change during the gap.
- Load during operation: `pat`=`01`; after sampling `0`, assert `pat_load` with `pat_in`=`10` while `A`=1 → no pulse, `armed`=0. The following input `1,0` → one pulse.
- Saturation and clear (`CNT_W`=2): 5 matches → `match_cnt`=3. Then `cnt_clr` on the same edge as a match → `y`=1 and `match_cnt`=0.
- Asynchronous reset mid-sequence: assert `reset` between clock edges after a partial match → `y`, `armed`, `match_cnt` go to 0 immediately. `pat` returns to `PAT_RST`.
